// File: rtl/serv_bus_pkg.sv
// Shared types and constants for the SERV ibus/dbus memory-port scheduler.
package serv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2,
    RESP = 2'd3
  } sched_state_t;

  localparam logic [3:0] SCHED_IBUS_SEL = 4'hF;

endpackage

// File: rtl/serv_bus_wdt.sv
// Saturating cycle counter that flags the last permitted cycle of a transfer.
module serv_bus_wdt #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

  // count holds the cycles already spent, so the MAX-th cycle is when it reads MAX-1
  assign expired = run && (count >= W'(MAX - 1));

endmodule

// File: rtl/serv_bus_sched.sv
// Round-robin scheduler sharing one Wishbone memory port between SERV ibus and dbus,
// with a registered response and a sticky watchdog timeout.
module serv_bus_sched
  import serv_bus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_grant_d,
  output logic        o_timeout
);

  localparam int   WDT_MAX = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam logic WDT_EN  = (TIMEOUT != 0);

  sched_state_t state, state_nxt;
  logic         last_d;
  logic [31:0]  resp_q;
  logic         timeout_q;
  logic         busy;
  logic         req_cyc;
  logic         wdt_expired;

  assign busy    = (state == IBUS) || (state == DBUS);
  assign req_cyc = (state == DBUS) ? i_dbus_cyc : i_ibus_cyc;

  serv_bus_wdt #(
    .MAX(WDT_MAX)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (i_rst_n),
    .clear  (!busy),
    .run    (busy && WDT_EN),
    .expired(wdt_expired)
  );

  // Abort beats ack, and ack beats watchdog expiry in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_dbus_cyc && (!i_ibus_cyc || !last_d)) state_nxt = DBUS;
        else if (i_ibus_cyc)                       state_nxt = IBUS;
      end
      IBUS, DBUS: begin
        if (!req_cyc)         state_nxt = IDLE;
        else if (i_wb_ack)    state_nxt = RESP;
        else if (wdt_expired) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // last_d doubles as the owner of the transfer in flight, since it updates on every grant
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == DBUS) last_d <= 1'b1;
      if (state == IDLE && state_nxt == IBUS) last_d <= 1'b0;
      if (busy && req_cyc) begin
        if (i_wb_ack) begin
          resp_q <= i_wb_rdt;
        end else if (wdt_expired) begin
          resp_q    <= '0;
          timeout_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_we  = 1'b0;
    case (state)
      IBUS: begin
        o_wb_adr = i_ibus_adr;
        o_wb_sel = SCHED_IBUS_SEL;
      end
      DBUS: begin
        o_wb_adr = i_dbus_adr;
        o_wb_dat = i_dbus_dat;
        o_wb_sel = i_dbus_sel;
        o_wb_we  = i_dbus_we;
      end
      default: ;
    endcase
  end

  assign o_wb_cyc   = busy;
  assign o_grant_d  = (state == DBUS);
  assign o_timeout  = timeout_q;
  assign o_ibus_ack = (state == RESP) && !last_d;
  assign o_dbus_ack = (state == RESP) && last_d;
  assign o_ibus_rdt = o_ibus_ack ? resp_q : '0;
  assign o_dbus_rdt = o_dbus_ack ? resp_q : '0;

endmodule

// File: tb/tb_serv_bus_sched.sv
// Directed bench for serv_bus_sched with TIMEOUT = 4 and a hand-driven memory port.
module tb_serv_bus_sched;

  logic        clk;
  logic        i_rst_n;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        o_grant_d;
  logic        o_timeout;

  int pass_count = 0;
  int check_count = 0;

  serv_bus_sched #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .i_rst_n   (i_rst_n),
    .i_ibus_adr(i_ibus_adr),
    .i_ibus_cyc(i_ibus_cyc),
    .o_ibus_rdt(o_ibus_rdt),
    .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr),
    .i_dbus_dat(i_dbus_dat),
    .i_dbus_sel(i_dbus_sel),
    .i_dbus_we (i_dbus_we),
    .i_dbus_cyc(i_dbus_cyc),
    .o_dbus_rdt(o_dbus_rdt),
    .o_dbus_ack(o_dbus_ack),
    .o_wb_adr  (o_wb_adr),
    .o_wb_dat  (o_wb_dat),
    .o_wb_sel  (o_wb_sel),
    .o_wb_we   (o_wb_we),
    .o_wb_cyc  (o_wb_cyc),
    .i_wb_rdt  (i_wb_rdt),
    .i_wb_ack  (i_wb_ack),
    .o_grant_d (o_grant_d),
    .o_timeout (o_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic ic, input logic [31:0] ia,
                                input logic dc, input logic [31:0] da,
                                input logic [31:0] dd, input logic [3:0] ds, input logic dw);
    i_ibus_cyc = ic;
    i_ibus_adr = ia;
    i_dbus_cyc = dc;
    i_dbus_adr = da;
    i_dbus_dat = dd;
    i_dbus_sel = ds;
    i_dbus_we  = dw;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_wb_cyc"}, {31'd0, o_wb_cyc}, 32'd0);
    check_output({tag, "_wb_adr"}, o_wb_adr, 32'd0);
    check_output({tag, "_wb_we"}, {31'd0, o_wb_we}, 32'd0);
    check_output({tag, "_wb_sel"}, {28'd0, o_wb_sel}, 32'd0);
    check_output({tag, "_acks"}, {30'd0, o_ibus_ack, o_dbus_ack}, 32'd0);
    check_output({tag, "_grant_d"}, {31'd0, o_grant_d}, 32'd0);
    check_output({tag, "_timeout"}, {31'd0, o_timeout}, 32'd0);
  endtask

  initial begin
    i_rst_n  = 1'b1;
    i_wb_ack = 1'b0;
    i_wb_rdt = '0;
    apply_stimulus(1'b0, '0, 1'b0, '0, '0, 4'h0, 1'b0);
    #1 i_rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) i_rst_n = 1'b1;
    tick();

    // Both requesters held high: expect d, i, d, i with one idle cycle between
    $display("[TB] round robin");
    apply_stimulus(1'b1, 32'h40, 1'b1, 32'h200, '0, 4'hF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output($sformatf("rr%0d_grant_d", k), {31'd0, o_grant_d}, {31'd0, (k % 2) == 0});
      check_output($sformatf("rr%0d_wb_adr", k), o_wb_adr, ((k % 2) == 0) ? 32'h200 : 32'h40);
      i_wb_ack = 1'b1;
      i_wb_rdt = 32'hA0 + k;
      tick();
      i_wb_ack = 1'b0;
      check_output($sformatf("rr%0d_acks", k), {30'd0, o_ibus_ack, o_dbus_ack},
                   ((k % 2) == 0) ? 32'd1 : 32'd2);
      check_output($sformatf("rr%0d_rdt", k), ((k % 2) == 0) ? o_dbus_rdt : o_ibus_rdt, 32'hA0 + k);
      if (k == 3) apply_stimulus(1'b0, '0, 1'b0, '0, '0, 4'h0, 1'b0);
      tick();
      check_output($sformatf("rr%0d_idle_cyc", k), {31'd0, o_wb_cyc}, 32'd0);
    end

    $display("[TB] zero-wait fetch");
    apply_stimulus(1'b1, 32'h8, 1'b0, '0, '0, 4'h0, 1'b0);
    tick();
    check_output("fetch_wb_cyc", {31'd0, o_wb_cyc}, 32'd1);
    check_output("fetch_wb_adr", o_wb_adr, 32'h8);
    check_output("fetch_wb_sel", {28'd0, o_wb_sel}, 32'hF);
    check_output("fetch_wb_we", {31'd0, o_wb_we}, 32'd0);
    i_wb_ack = 1'b1;
    i_wb_rdt = 32'h0000_0013;
    tick();
    i_wb_ack = 1'b0;
    i_wb_rdt = '0;
    check_output("fetch_ack", {30'd0, o_ibus_ack, o_dbus_ack}, 32'd2);
    check_output("fetch_rdt", o_ibus_rdt, 32'h13);
    i_ibus_cyc = 1'b0;
    tick();
    check_output("fetch_ack_drop", {31'd0, o_ibus_ack}, 32'd0);
    check_output("fetch_rdt_zero", o_ibus_rdt, 32'd0);

    // Ack on the 4th busy cycle coincides with watchdog expiry; the ack must win
    $display("[TB] store with 3 wait states");
    apply_stimulus(1'b0, '0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 1'b1);
    tick();
    check_output("store_wb_we", {31'd0, o_wb_we}, 32'd1);
    check_output("store_wb_adr", o_wb_adr, 32'h100);
    check_output("store_wb_dat", o_wb_dat, 32'hDEAD_BEEF);
    check_output("store_wb_sel", {28'd0, o_wb_sel}, 32'h3);
    check_output("store_grant_d", {31'd0, o_grant_d}, 32'd1);
    tick();
    tick();
    tick();
    check_output("store_wait_ack", {31'd0, o_dbus_ack}, 32'd0);
    check_output("store_wait_cyc", {31'd0, o_wb_cyc}, 32'd1);
    i_wb_ack = 1'b1;
    i_wb_rdt = 32'h0000_00AA;
    tick();
    i_wb_ack = 1'b0;
    check_output("store_ack", {30'd0, o_ibus_ack, o_dbus_ack}, 32'd1);
    check_output("store_rdt", o_dbus_rdt, 32'hAA);
    check_output("store_no_timeout", {31'd0, o_timeout}, 32'd0);
    apply_stimulus(1'b0, '0, 1'b0, '0, '0, 4'h0, 1'b0);
    tick();

    $display("[TB] abort with simultaneous ack");
    apply_stimulus(1'b0, '0, 1'b1, 32'h300, '0, 4'hF, 1'b0);
    tick();
    check_output("abort_grant_d", {31'd0, o_grant_d}, 32'd1);
    tick();
    i_dbus_cyc = 1'b0;
    i_wb_ack   = 1'b1;
    i_wb_rdt   = 32'h1111_2222;
    i_ibus_cyc = 1'b1;
    i_ibus_adr = 32'h20;
    tick();
    i_wb_ack = 1'b0;
    check_output("abort_no_ack", {30'd0, o_ibus_ack, o_dbus_ack}, 32'd0);
    check_output("abort_idle_cyc", {31'd0, o_wb_cyc}, 32'd0);
    tick();
    check_output("abort_next_cyc", {31'd0, o_wb_cyc}, 32'd1);
    check_output("abort_next_adr", o_wb_adr, 32'h20);
    check_output("abort_next_grant", {31'd0, o_grant_d}, 32'd0);
    i_wb_ack = 1'b1;
    i_wb_rdt = 32'h0000_0077;
    tick();
    i_wb_ack = 1'b0;
    check_output("abort_next_rdt", o_ibus_rdt, 32'h77);
    i_ibus_cyc = 1'b0;
    tick();

    $display("[TB] watchdog timeout");
    apply_stimulus(1'b1, 32'h44, 1'b0, '0, '0, 4'h0, 1'b0);
    i_wb_rdt = 32'hFFFF_FFFF;
    tick();
    check_output("to_cyc_rise", {31'd0, o_wb_cyc}, 32'd1);
    check_output("to_pre_flag", {31'd0, o_timeout}, 32'd0);
    tick();
    tick();
    tick();
    check_output("to_still_waiting", {30'd0, o_ibus_ack, o_wb_cyc}, 32'd1);
    tick();
    check_output("to_ack", {30'd0, o_ibus_ack, o_dbus_ack}, 32'd2);
    check_output("to_rdt_zero", o_ibus_rdt, 32'd0);
    check_output("to_flag", {31'd0, o_timeout}, 32'd1);
    i_ibus_cyc = 1'b0;
    i_wb_rdt   = '0;
    tick();
    apply_stimulus(1'b0, '0, 1'b1, 32'h10, '0, 4'hF, 1'b0);
    tick();
    i_wb_ack = 1'b1;
    i_wb_rdt = 32'h1234;
    tick();
    i_wb_ack = 1'b0;
    check_output("to_later_rdt", o_dbus_rdt, 32'h1234);
    check_output("to_sticky", {31'd0, o_timeout}, 32'd1);
    i_dbus_cyc = 1'b0;
    tick();

    $display("[TB] async reset mid-transfer");
    apply_stimulus(1'b0, '0, 1'b1, 32'h500, 32'h5555_AAAA, 4'hF, 1'b1);
    tick();
    tick();
    tick();
    check_output("rst_pre_cyc", {31'd0, o_wb_cyc}, 32'd1);
    #2 i_rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    i_dbus_cyc = 1'b0;
    @(negedge clk) i_rst_n = 1'b1;
    tick();
    apply_stimulus(1'b1, 32'h8, 1'b0, '0, '0, 4'h0, 1'b0);
    tick();
    check_output("rst_fetch_cyc", {31'd0, o_wb_cyc}, 32'd1);
    i_wb_ack = 1'b1;
    i_wb_rdt = 32'h0000_0013;
    tick();
    i_wb_ack = 1'b0;
    check_output("rst_fetch_ack", {31'd0, o_ibus_ack}, 32'd1);
    check_output("rst_fetch_rdt", o_ibus_rdt, 32'h13);
    i_ibus_cyc = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/serv_bus_sched.md
# serv_bus_sched

Two-requester bus scheduler that shares one Wishbone-style memory port between the SERV core's instruction bus (ibus) and data bus (dbus). It sits between serv_top and the single-port memory model used in simulation and formal runs. It arbitrates between the two buses and sequences each transfer through a small FSM. It registers the response back to the winning requester and aborts stalled transfers with a watchdog timeout.

## Interface
- TIMEOUT, 255: maximum number of cycles a granted transfer waits for i_wb_ack; 0 disables the watchdog.
- clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_ibus_adr  in  32  instruction fetch address.
- i_ibus_cyc  in  1  instruction fetch request, held until acked.
- o_ibus_rdt  out  32  fetched instruction, valid while o_ibus_ack.
- o_ibus_ack  out  1  one-cycle fetch completion.
- i_dbus_adr  in  32  data address.
- i_dbus_dat  in  32  store data.
- i_dbus_sel  in  4  byte enables.
- i_dbus_we  in  1  1 = store, 0 = load.
- i_dbus_cyc  in  1  data request, held until acked.
- o_dbus_rdt  out  32  load data, valid while o_dbus_ack.
- o_dbus_ack  out  1  one-cycle data completion.
- o_wb_adr  out  32  memory address.
- o_wb_dat  out  32  memory write data.
- o_wb_sel  out  4  memory byte enables; 4'hF for ibus.
- o_wb_we  out  1  memory write enable; 0 for ibus.
- o_wb_cyc  out  1  memory request.
- i_wb_rdt  in  32  memory read data.
- i_wb_ack  in  1  memory completion; ignored while o_wb_cyc = 0.
- o_grant_d  out  1  1 while the dbus owns the port.
- o_timeout  out  1  sticky; set on the first watchdog expiry; cleared only by reset.

## Operation
- FSM states: IDLE, IBUS, DBUS, RESP.
- IDLE:
  - Only i_ibus_cyc set -> IBUS. Only i_dbus_cyc set -> DBUS.
  - Both set -> round robin on the last_d bit. DBUS if last_d = 0, else IBUS. last_d updates on every grant.
- IBUS/DBUS:
  - o_wb_cyc = 1. o_wb_adr/dat/sel/we are driven combinationally from the granted requester.
  - i_wb_ack -> capture i_wb_rdt into the response register, go to RESP.
  - Granted requester drops cyc before ack (abort) -> IDLE, no ack, watchdog cleared.
  - Watchdog reaches TIMEOUT without ack -> capture 32'h0, set o_timeout, go to RESP.
- RESP:
  - Pulse o_ibus_ack or o_dbus_ack for the owning requester only. The rdt outputs show the response register.
  - Always returns to IDLE next cycle. Requests are not sampled in RESP.
- o_ibus_rdt and o_dbus_rdt are 0 whenever their ack is low.
- The watchdog counts cycles spent in IBUS/DBUS. It clears on entry to those states. Its width is $clog2(TIMEOUT+1), and it saturates rather than wrapping.
- Reset value of every output: 0. Reset also returns the FSM to IDLE, clears last_d, the response register and the watchdog, and takes effect immediately from any state.

## Timing
- Zero-wait memory: request seen in IDLE at cycle 0 -> o_wb_cyc at cycle 1 -> i_wb_ack at cycle 1 -> requester ack at cycle 2. Minimum latency is 2 cycles.
- A memory ack at cycle N produces the requester ack at cycle N+1. Each transfer takes wait states + 2 cycles.
- Back-to-back transfers: the next grant occurs no earlier than the cycle after RESP. The port idles at least one cycle between transfers.
- Timeout: if i_wb_ack never arrives, RESP is entered TIMEOUT cycles after o_wb_cyc rose. o_timeout is high from the cycle of the zero ack onward.
- Ack in the same cycle the watchdog expires: the ack wins. Real data is captured and o_timeout is not set.
- Ack in the same cycle the requester aborts: the abort wins and the ack is discarded.

## Structure
- Package serv_bus_pkg: state enum sched_state_t {IDLE, IBUS, DBUS, RESP}, constant SCHED_IBUS_SEL = 4'hF.
- One sub-module, serv_bus_wdt: parameterised saturating counter with inputs clear and run, output expired. It is instantiated once and tied off when TIMEOUT = 0.
- The remaining FSM, grant mux and response register live in serv_bus_sched.

## Test plan
- Fetch only, ibus_adr 32'h8, zero-wait memory returning 32'h0000_0013 -> o_wb_cyc at cycle 1 with adr 32'h8 and sel 4'hF; o_ibus_ack with rdt 32'h13 at cycle 2.
- Store, dbus_adr 32'h100, dat 32'hDEAD_BEEF, sel 4'b0011, memory acks after 3 wait states -> o_wb_we = 1 with matching adr/dat/sel; o_dbus_ack 5 cycles after the request cycle.
- Both requests held high continuously for 4 transfers from reset -> grant order dbus, ibus, dbus, ibus; exactly one ack per RESP.
- TIMEOUT = 4, memory never acks an ibus fetch -> o_ibus_ack with rdt 0 exactly 4 cycles after o_wb_cyc rose; o_timeout stays 1 through later successful transfers.
- i_rst_n pulled low mid-DBUS with 2 wait states elapsed -> all outputs 0 asynchronously; after release, a new fetch completes with normal 2-cycle latency.
- dbus drops cyc at wait state 1 while the memory acks in the same cycle -> no o_dbus_ack; FSM back in IDLE; a subsequent ibus fetch is granted next cycle.
